// File: rtl/chip8_call_ret_ctrl_pkg.sv
// Shared types for the CHIP-8 CALL/RET stack sequencer: stack op codes,
// sequencer states and the hardware stack depth.
package chip8_call_ret_ctrl_pkg;

   localparam int CHIP8_STACK_DEPTH = 16;

   typedef enum logic [1:0] {
      STACK_HOLD = 2'd0,
      STACK_PUSH = 2'd1,
      STACK_POP  = 2'd2
   } stack_op_t;

   typedef enum logic [2:0] {
      CR_IDLE     = 3'd0,
      CR_PUSH     = 3'd1,
      CR_POP      = 3'd2,
      CR_POP_WAIT = 3'd3,
      CR_FINISH   = 3'd4
   } callret_state_t;

endpackage

// File: rtl/chip8_call_ret_ctrl_if.sv
// CPU-side request/response and Chip8_Stack signals of the CALL/RET sequencer.
interface chip8_call_ret_ctrl_if;
   import chip8_call_ret_ctrl_pkg::*;

   logic        req_call;
   logic        req_ret;
   logic [11:0] call_target;
   logic [15:0] pc_in;
   logic        clear_err;
   stack_op_t   stack_op;
   logic [15:0] stack_writedata;
   logic [15:0] stack_outdata;
   logic [15:0] pc_out;
   logic        pc_load;
   logic        done;
   logic        busy;
   logic [4:0]  depth;
   logic        overflow;
   logic        underflow;

   modport slave (
      input  req_call, req_ret, call_target, pc_in, clear_err, stack_outdata,
      output stack_op, stack_writedata, pc_out, pc_load, done, busy, depth,
             overflow, underflow
   );

   modport master (
      output req_call, req_ret, call_target, pc_in, clear_err, stack_outdata,
      input  stack_op, stack_writedata, pc_out, pc_load, done, busy, depth,
             overflow, underflow
   );

endinterface

// File: rtl/chip8_call_ret_ctrl.sv
// Sequences Chip8_Stack for CALL (2nnn) and RET (00EE): one stack op per
// sequence, depth tracking, sticky overflow/underflow and a PC load strobe.
module chip8_call_ret_ctrl
   import chip8_call_ret_ctrl_pkg::*;
#(
   parameter int DEPTH       = CHIP8_STACK_DEPTH,
   parameter int POP_LATENCY = 1
) (
   input logic             cpu_clk,
   input logic             reset,
   chip8_call_ret_ctrl_if.slave bus
);

   localparam logic [4:0] DEPTH_C     = 5'(DEPTH);
   localparam logic [1:0] WAIT_LAST_C = (POP_LATENCY > 0) ? 2'(POP_LATENCY - 1) : 2'd0;

   callret_state_t state_r, state_s;
   stack_op_t      stack_op_r, stack_op_s;
   logic [15:0]    wdata_r, wdata_s;
   logic [15:0]    tgt_r, tgt_s;
   logic [15:0]    pc_out_r, pc_out_s;
   logic [1:0]     wait_cnt_r, wait_cnt_s;
   logic [4:0]     depth_r, depth_s;
   logic           pc_load_r, pc_load_s;
   logic           done_r, done_s;
   logic           busy_r;
   logic           overflow_r, overflow_s;
   logic           underflow_r, underflow_s;
   logic           set_ovf_s, set_udf_s;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s    = state_r;
      stack_op_s = STACK_HOLD;
      wdata_s    = wdata_r;
      tgt_s      = tgt_r;
      pc_out_s   = pc_out_r;
      wait_cnt_s = wait_cnt_r;
      depth_s    = depth_r;
      pc_load_s  = 1'b0;
      done_s     = 1'b0;
      set_ovf_s  = 1'b0;
      set_udf_s  = 1'b0;
      case (state_r)
         CR_IDLE: begin
            if (bus.req_call) begin
               if (depth_r == DEPTH_C) begin
                  set_ovf_s = 1'b1;
                  done_s    = 1'b1;
               end else begin
                  wdata_s    = bus.pc_in + 16'd2;
                  tgt_s      = {4'h0, bus.call_target};
                  stack_op_s = STACK_PUSH;
                  state_s    = CR_PUSH;
               end
            end else if (bus.req_ret) begin
               if (depth_r == 5'd0) begin
                  set_udf_s = 1'b1;
                  done_s    = 1'b1;
               end else begin
                  stack_op_s = STACK_POP;
                  state_s    = CR_POP;
               end
            end else begin
               state_s = CR_IDLE;
            end
         end
         CR_PUSH: begin
            depth_s   = depth_r + 5'd1;
            pc_out_s  = tgt_r;
            pc_load_s = 1'b1;
            done_s    = 1'b1;
            state_s   = CR_FINISH;
         end
         CR_POP: begin
            depth_s = depth_r - 5'd1;
            // With zero latency the popped value is already on stack_outdata.
            if (POP_LATENCY == 0) begin
               pc_out_s  = bus.stack_outdata;
               pc_load_s = 1'b1;
               done_s    = 1'b1;
               state_s   = CR_FINISH;
            end else begin
               wait_cnt_s = 2'd0;
               state_s    = CR_POP_WAIT;
            end
         end
         CR_POP_WAIT: begin
            if (wait_cnt_r == WAIT_LAST_C) begin
               pc_out_s  = bus.stack_outdata;
               pc_load_s = 1'b1;
               done_s    = 1'b1;
               state_s   = CR_FINISH;
            end else begin
               wait_cnt_s = wait_cnt_r + 2'd1;
            end
         end
         CR_FINISH: begin
            state_s = CR_IDLE;
         end
         default: begin
            state_s = CR_IDLE;
         end
      endcase
      overflow_s  = set_ovf_s ? 1'b1 : (bus.clear_err ? 1'b0 : overflow_r);
      underflow_s = set_udf_s ? 1'b1 : (bus.clear_err ? 1'b0 : underflow_r);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_r     <= CR_IDLE;
         stack_op_r  <= STACK_HOLD;
         wdata_r     <= 16'd0;
         tgt_r       <= 16'd0;
         pc_out_r    <= 16'd0;
         wait_cnt_r  <= 2'd0;
         depth_r     <= 5'd0;
         pc_load_r   <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         stack_op_r  <= stack_op_s;
         wdata_r     <= wdata_s;
         tgt_r       <= tgt_s;
         pc_out_r    <= pc_out_s;
         wait_cnt_r  <= wait_cnt_s;
         depth_r     <= depth_s;
         pc_load_r   <= pc_load_s;
         done_r      <= done_s;
         busy_r      <= (state_s != CR_IDLE);
         overflow_r  <= overflow_s;
         underflow_r <= underflow_s;
      end
   end

   assign bus.stack_op        = stack_op_r;
   assign bus.stack_writedata = wdata_r;
   assign bus.pc_out          = pc_out_r;
   assign bus.pc_load         = pc_load_r;
   assign bus.done            = done_r;
   assign bus.busy            = busy_r;
   assign bus.depth           = depth_r;
   assign bus.overflow        = overflow_r;
   assign bus.underflow       = underflow_r;

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Bench for chip8_call_ret_ctrl: behavioural Chip8_Stack, transaction-level
// reference model compared every cycle, directed scenarios and random traffic.
module tb_chip8_call_ret_ctrl;
   import chip8_call_ret_ctrl_pkg::*;

   localparam int LAT = 1;

   typedef enum int {K_NONE, K_CALL, K_RET, K_OVF, K_UDF} kind_t;

   logic cpu_clk = 1'b0;
   logic reset   = 1'b1;
   int   cyc     = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;

   chip8_call_ret_ctrl_if bus ();

   chip8_call_ret_ctrl #(.DEPTH(16), .POP_LATENCY(LAT)) dut (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   always @(posedge cpu_clk) cyc <= cyc + 1;

   // Behavioural Chip8_Stack; output carries junk except when the popped value is due.
   logic [15:0] mem [16];
   int          sp = 0;
   logic [15:0] pipe [4];
   always @(posedge cpu_clk) begin
      pipe[0] <= 16'($urandom);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (reset) begin
         sp <= 0;
      end else if (bus.stack_op == STACK_PUSH && sp < 16) begin
         mem[sp] <= bus.stack_writedata;
         sp      <= sp + 1;
      end else if (bus.stack_op == STACK_POP && sp > 0) begin
         pipe[0] <= mem[sp-1];
         sp      <= sp - 1;
      end
   end
   assign bus.stack_outdata = (LAT == 0) ? ((sp > 0) ? mem[sp-1] : 16'hDEAD)
                                         : pipe[(LAT == 0) ? 0 : LAT - 1];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, outputs derived from cycle offset.
   kind_t       t_kind = K_NONE;
   int          t_start = -100;
   logic [15:0] t_wd, t_pc;
   logic [4:0]  t_depth_after;
   logic [4:0]  m_depth = 5'd0;
   logic        m_ovf = 1'b0, m_udf = 1'b0;
   logic [15:0] m_q[$];
   bit          valid = 1'b0;

   initial begin
      forever begin
         int        dt;
         stack_op_t e_op;
         logic      e_pcl, e_done, e_busy, err_o, err_u;
         @(negedge cpu_clk);
         dt     = cyc - t_start;
         e_op   = STACK_HOLD;
         e_pcl  = 1'b0;
         e_done = 1'b0;
         e_busy = 1'b0;
         if ((t_kind == K_CALL || t_kind == K_RET) && dt == 2) m_depth = t_depth_after;
         if (t_kind == K_CALL) begin
            e_op   = (dt == 1) ? STACK_PUSH : STACK_HOLD;
            e_pcl  = (dt == 2);
            e_busy = (dt >= 1 && dt <= 2);
         end else if (t_kind == K_RET) begin
            e_op   = (dt == 1) ? STACK_POP : STACK_HOLD;
            e_pcl  = (dt == 2 + LAT);
            e_busy = (dt >= 1 && dt <= 2 + LAT);
         end
         e_done = e_pcl || ((t_kind == K_OVF || t_kind == K_UDF) && dt == 1);
         if (valid) begin
            chk("stack_op", 16'(bus.stack_op), 16'(e_op));
            chk("busy", 16'(bus.busy), 16'(e_busy));
            chk("pc_load", 16'(bus.pc_load), 16'(e_pcl));
            chk("done", 16'(bus.done), 16'(e_done));
            chk("depth", 16'(bus.depth), 16'(m_depth));
            chk("overflow", 16'(bus.overflow), 16'(m_ovf));
            chk("underflow", 16'(bus.underflow), 16'(m_udf));
            if (e_op == STACK_PUSH) chk("writedata", bus.stack_writedata, t_wd);
            if (e_pcl) chk("pc_out", bus.pc_out, t_pc);
         end
         if (reset) begin
            valid   = 1'b1;
            t_kind  = K_NONE;
            t_start = -100;
            m_depth = 5'd0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_q.delete();
         end else if (valid) begin
            err_o = 1'b0;
            err_u = 1'b0;
            if (!e_busy && bus.req_call) begin
               t_start = cyc;
               if (m_depth == 5'd16) begin
                  err_o  = 1'b1;
                  t_kind = K_OVF;
               end else begin
                  t_kind        = K_CALL;
                  t_wd          = bus.pc_in + 16'd2;
                  t_pc          = {4'h0, bus.call_target};
                  t_depth_after = m_depth + 5'd1;
                  m_q.push_back(t_wd);
               end
            end else if (!e_busy && bus.req_ret) begin
               t_start = cyc;
               if (m_depth == 5'd0) begin
                  err_u  = 1'b1;
                  t_kind = K_UDF;
               end else begin
                  t_kind        = K_RET;
                  t_pc          = m_q.pop_back();
                  t_depth_after = m_depth - 5'd1;
               end
            end
            m_ovf = err_o ? 1'b1 : (bus.clear_err ? 1'b0 : m_ovf);
            m_udf = err_u ? 1'b1 : (bus.clear_err ? 1'b0 : m_udf);
         end
      end
   end

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   // Drive a one-cycle request; returns #1 into the cycle after the request.
   task automatic drive_req(input logic c, input logic r, input logic [15:0] pc, input logic [11:0] tgt);
      bus.req_call    = c;
      bus.req_ret     = r;
      bus.pc_in       = pc;
      bus.call_target = tgt;
      step();
      bus.req_call    = 1'b0;
      bus.req_ret     = 1'b0;
      bus.pc_in       = 16'($urandom);
      bus.call_target = 12'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_call = 1'b0; bus.req_ret = 1'b0; bus.clear_err = 1'b0;
      bus.pc_in = 16'd0; bus.call_target = 12'd0;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_depth", 16'(bus.depth), 16'd0);
      chk("rst_pc_out", bus.pc_out, 16'h0000);
      chk("rst_op", 16'(bus.stack_op), 16'(STACK_HOLD));
      chk("rst_busy", 16'(bus.busy), 16'd0);
      step();

      // First CALL, then RET back to the return address.
      drive_req(1'b1, 1'b0, 16'h0200, 12'h3A4);
      chk("call_op", 16'(bus.stack_op), 16'(STACK_PUSH));
      chk("call_wd", bus.stack_writedata, 16'h0202);
      step();
      chk("call_pcl", 16'(bus.pc_load), 16'd1);
      chk("call_pc", bus.pc_out, 16'h03A4);
      chk("call_depth", 16'(bus.depth), 16'd1);
      repeat (2) step();
      drive_req(1'b0, 1'b1, 16'h0000, 12'h000);
      chk("ret_op", 16'(bus.stack_op), 16'(STACK_POP));
      repeat (1 + LAT) step();
      chk("ret_pcl", 16'(bus.pc_load), 16'd1);
      chk("ret_pc", bus.pc_out, 16'h0202);
      chk("ret_depth", 16'(bus.depth), 16'd0);
      repeat (2) step();

      // Fill the stack, overflow once, then unwind in LIFO order.
      for (int k = 0; k < 16; k++) begin
         drive_req(1'b1, 1'b0, 16'h0200 + 16'(2 * k), 12'($urandom));
         repeat (3) step();
      end
      drive_req(1'b1, 1'b0, 16'h0300, 12'h123);
      chk("ovf_flag", 16'(bus.overflow), 16'd1);
      chk("ovf_done", 16'(bus.done), 16'd1);
      chk("ovf_op", 16'(bus.stack_op), 16'(STACK_HOLD));
      chk("ovf_depth", 16'(bus.depth), 16'd16);
      step();
      for (int i = 0; i < 16; i++) begin
         drive_req(1'b0, 1'b1, 16'h0000, 12'h000);
         repeat (1 + LAT) step();
         chk("lifo_pc", bus.pc_out, 16'h0220 - 16'(2 * i));
         repeat (2) step();
      end

      // Underflow and clearing it.
      drive_req(1'b0, 1'b1, 16'h0000, 12'h000);
      chk("udf_flag", 16'(bus.underflow), 16'd1);
      chk("udf_done", 16'(bus.done), 16'd1);
      chk("udf_busy", 16'(bus.busy), 16'd0);
      bus.clear_err = 1'b1;
      step();
      bus.clear_err = 1'b0;
      chk("udf_clear", 16'(bus.underflow), 16'd0);
      chk("ovf_clear", 16'(bus.overflow), 16'd0);

      // CALL beats RET; a RET while busy is dropped.
      for (int k = 0; k < 2; k++) begin
         drive_req(1'b1, 1'b0, 16'h0400, 12'h400);
         repeat (3) step();
      end
      drive_req(1'b1, 1'b1, 16'h0500, 12'h500);
      repeat (3) step();
      chk("both_depth", 16'(bus.depth), 16'd3);
      drive_req(1'b1, 1'b0, 16'h0600, 12'h600);
      bus.req_ret = 1'b1;
      step();
      bus.req_ret = 1'b0;
      repeat (3) step();
      chk("busy_ret_depth", 16'(bus.depth), 16'd4);

      // Reset in the PUSH cycle, then a normal CALL.
      drive_req(1'b1, 1'b0, 16'h0700, 12'h700);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rpush_depth", 16'(bus.depth), 16'd0);
      chk("rpush_op", 16'(bus.stack_op), 16'(STACK_HOLD));
      chk("rpush_pcl", 16'(bus.pc_load), 16'd0);
      chk("rpush_done", 16'(bus.done), 16'd0);
      step();
      drive_req(1'b1, 1'b0, 16'h0800, 12'h801);
      step();
      chk("after_rst_pc", bus.pc_out, 16'h0801);
      chk("after_rst_depth", 16'(bus.depth), 16'd1);
      repeat (2) step();

      // Reset in POP_WAIT, then a normal CALL.
      drive_req(1'b0, 1'b1, 16'h0000, 12'h000);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rwait_depth", 16'(bus.depth), 16'd0);
      chk("rwait_op", 16'(bus.stack_op), 16'(STACK_HOLD));
      chk("rwait_pcl", 16'(bus.pc_load), 16'd0);
      chk("rwait_done", 16'(bus.done), 16'd0);
      step();
      drive_req(1'b1, 1'b0, 16'hFFFE, 12'hABC);
      chk("wrap_wd", bus.stack_writedata, 16'h0000);
      repeat (3) step();

      // Random traffic, including requests while busy and occasional resets.
      for (int it = 0; it < 400; it++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         bus.clear_err = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 60) == 0) reset = 1'b1;
         drive_req(sel < 5 || sel == 8, (sel >= 5 && sel < 8) || sel == 8,
                   ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom), 12'($urandom));
         bus.clear_err = 1'b0;
         reset = 1'b0;
         repeat ($urandom_range(0, 5)) step();
      end
      repeat (6) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
